// File: rtl/issue_credit_ctrl_pkg.sv
// issue_credit_ctrl shared types: FSM encoding, HOLD length, default sizes.
// Default sizes are shared with the ROB/RS/LSB modules.
package issue_credit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int HOLD_LEN     = 2;
  localparam int DEF_ROB_SIZE = 16;
  localparam int DEF_RS_SIZE  = 16;
  localparam int DEF_LSB_SIZE = 16;
  localparam int DEF_CNT_W    = 5;

endpackage

// File: rtl/issue_credit_ctrl_if.sv
// Issue/release/stall bundle between front end and credit controller.
// ISSUE_CREDIT_STATS_EN adds the stall statistics counters.
interface issue_credit_ctrl_if
  import issue_credit_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             flush;
  logic             issue_req;
  logic             issue_is_ls;
  logic             rob_release;
  logic             rs_release;
  logic             lsb_release;
  logic             is_any_full;
  logic             issue_fire;
  logic [CNT_W-1:0] rob_free;
  logic [CNT_W-1:0] rs_free;
  logic [CNT_W-1:0] lsb_free;
  logic             err_overflow;
  logic             err_underflow;
`ifdef ISSUE_CREDIT_STATS_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      stall_rob;
  logic [31:0]      stall_rs;
  logic [31:0]      stall_lsb;
`endif

  modport master (
    output flush, issue_req, issue_is_ls,
    output rob_release, rs_release, lsb_release,
    input  is_any_full, issue_fire,
    input  rob_free, rs_free, lsb_free,
    input  err_overflow, err_underflow
`ifdef ISSUE_CREDIT_STATS_EN
    , input stall_cycles, stall_rob
    , input stall_rs, stall_lsb
`endif
  );

  modport slave (
    input  flush, issue_req, issue_is_ls,
    input  rob_release, rs_release, lsb_release,
    output is_any_full, issue_fire,
    output rob_free, rs_free, lsb_free,
    output err_overflow, err_underflow
`ifdef ISSUE_CREDIT_STATS_EN
    , output stall_cycles, stall_rob
    , output stall_rs, stall_lsb
`endif
  );

endinterface

// File: rtl/issue_credit_ctrl_credit_counter.sv
// Saturating free-slot counter: debit/credit by one, reload to SIZE.
// Simultaneous debit and credit cancel; boundary hits raise pulses.
module credit_counter
  import issue_credit_ctrl_pkg::*;
#(
  parameter int SIZE  = DEF_ROB_SIZE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             debit,
  input  logic             credit,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(SIZE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign zero  = (cnt_q == '0);
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (en) begin
      if (load) begin
        cnt_d = FULL;
      end else if (debit && !credit) begin
        if (zero) unf = 1'b1;
        else      cnt_d = cnt_q - CNT_W'(1);
      end else if (credit && !debit) begin
        if (cnt_q == FULL) ovf = 1'b1;
        else               cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= FULL;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/issue_credit_ctrl.sv
// Credit-based issue stall for ROB/RS/LSB with reset/flush recovery.
// Optional stall statistics under ISSUE_CREDIT_STATS_EN.
module issue_credit_ctrl
  import issue_credit_ctrl_pkg::*;
#(
  parameter int ROB_SIZE = DEF_ROB_SIZE,
  parameter int RS_SIZE  = DEF_RS_SIZE,
  parameter int LSB_SIZE = DEF_LSB_SIZE,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  issue_credit_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [1:0] hold_q, hold_d;
  logic       err_ovf_q, err_ovf_d;
  logic       err_unf_q, err_unf_d;

  logic       run, load, full, fire;
  logic       rob_zero, rs_zero, lsb_zero;
  logic [2:0] ovf, unf;

  assign run  = (state_q == ST_RUN);
  assign full = !run | rob_zero | rs_zero | lsb_zero;
  assign fire = bus.issue_req & ~full & rdy;
  // Reload on the flush cycle too, so HOLD already shows SIZE.
  assign load = bus.flush | !run;

  credit_counter #(.SIZE(ROB_SIZE), .CNT_W(CNT_W)) u_rob (
    .clk, .rst, .en(rdy), .load,
    .debit(fire), .credit(bus.rob_release),
    .count(bus.rob_free), .zero(rob_zero),
    .ovf(ovf[0]), .unf(unf[0])
  );

  credit_counter #(.SIZE(RS_SIZE), .CNT_W(CNT_W)) u_rs (
    .clk, .rst, .en(rdy), .load,
    .debit(fire & ~bus.issue_is_ls),
    .credit(bus.rs_release),
    .count(bus.rs_free), .zero(rs_zero),
    .ovf(ovf[1]), .unf(unf[1])
  );

  credit_counter #(.SIZE(LSB_SIZE), .CNT_W(CNT_W)) u_lsb (
    .clk, .rst, .en(rdy), .load,
    .debit(fire & bus.issue_is_ls),
    .credit(bus.lsb_release),
    .count(bus.lsb_free), .zero(lsb_zero),
    .ovf(ovf[2]), .unf(unf[2])
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    err_ovf_d = err_ovf_q | (|ovf);
    err_unf_d = err_unf_q | (|unf);
    if (rdy) begin
      if (bus.flush) begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end else begin
        case (state_q)
          ST_INIT: state_d = ST_RUN;
          ST_HOLD: begin
            if (hold_q == 2'(HOLD_LEN - 1)) state_d = ST_RUN;
            else hold_d = hold_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      hold_q    <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign bus.is_any_full   = full;
  assign bus.issue_fire    = fire;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_unf_q;

`ifdef ISSUE_CREDIT_STATS_EN
  logic [31:0] st_cyc_q, st_cyc_d;
  logic [31:0] st_rob_q, st_rob_d;
  logic [31:0] st_rs_q,  st_rs_d;
  logic [31:0] st_lsb_q, st_lsb_d;
  logic        stall_ev;

  assign stall_ev = bus.issue_req & full & rdy & run;

  always_comb begin
    st_cyc_d = st_cyc_q + 32'(stall_ev);
    st_rob_d = st_rob_q + 32'(stall_ev & rob_zero);
    st_rs_d  = st_rs_q  + 32'(stall_ev & rs_zero);
    st_lsb_d = st_lsb_q + 32'(stall_ev & lsb_zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_cyc_q <= '0;
      st_rob_q <= '0;
      st_rs_q  <= '0;
      st_lsb_q <= '0;
    end else begin
      st_cyc_q <= st_cyc_d;
      st_rob_q <= st_rob_d;
      st_rs_q  <= st_rs_d;
      st_lsb_q <= st_lsb_d;
    end
  end

  assign bus.stall_cycles = st_cyc_q;
  assign bus.stall_rob    = st_rob_q;
  assign bus.stall_rs     = st_rs_q;
  assign bus.stall_lsb    = st_lsb_q;
`endif

endmodule

// File: tb/tb_issue_credit_ctrl.sv
// Bench for issue_credit_ctrl: directed scenarios plus random traffic
// checked every cycle against a slot-count model.
module tb_issue_credit_ctrl;

  localparam int ROB = 4;
  localparam int RS  = 16;
  localparam int LSB = 6;
  localparam int W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  issue_credit_ctrl_if #(.CNT_W(W)) bus ();

  issue_credit_ctrl #(
    .ROB_SIZE(ROB), .RS_SIZE(RS),
    .LSB_SIZE(LSB), .CNT_W(W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Model: free slots per structure plus remaining stalled cycles.
  int m_rob, m_rs, m_lsb, m_stall;
  bit m_ovf, m_unf;
  bit mvalid = 1'b0;

  function automatic bit m_full();
    return (m_stall > 0) || (m_rob == 0) ||
           (m_rs == 0) || (m_lsb == 0);
  endfunction

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic upd(inout int cnt, input int size,
                     input bit d, input bit c);
    if (d && c) return;
    if (d) begin
      if (cnt == 0) m_unf = 1'b1;
      else cnt--;
    end else if (c) begin
      if (cnt == size) m_ovf = 1'b1;
      else cnt++;
    end
  endtask

  always @(posedge clk) begin
    bit f;
    if (rst) begin
      m_stall = 1;
      m_rob = ROB; m_rs = RS; m_lsb = LSB;
      m_ovf = 1'b0; m_unf = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid && rdy) begin
      f = bus.issue_req && !m_full();
      if (bus.flush) begin
        m_stall = 2;
        m_rob = ROB; m_rs = RS; m_lsb = LSB;
      end else if (m_stall > 0) begin
        m_stall--;
      end else begin
        upd(m_rob, ROB, f, bus.rob_release);
        upd(m_rs, RS, f && !bus.issue_is_ls, bus.rs_release);
        upd(m_lsb, LSB, f && bus.issue_is_ls, bus.lsb_release);
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("is_any_full", int'(bus.is_any_full), int'(m_full()));
      chk("issue_fire", int'(bus.issue_fire),
          int'(bus.issue_req && rdy && !m_full()));
      chk("rob_free", int'(bus.rob_free), m_rob);
      chk("rs_free", int'(bus.rs_free), m_rs);
      chk("lsb_free", int'(bus.lsb_free), m_lsb);
      chk("err_overflow", int'(bus.err_overflow), int'(m_ovf));
      chk("err_underflow", int'(bus.err_underflow), int'(m_unf));
    end
  end

  task automatic set(bit req, bit ls, bit rr, bit sr,
                     bit lr, bit fl, bit rd);
    bus.issue_req   = req;
    bus.issue_is_ls = ls;
    bus.rob_release = rr;
    bus.rs_release  = sr;
    bus.lsb_release = lr;
    bus.flush       = fl;
    rdy             = rd;
  endtask

  initial begin
    int nf;
    set(0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    set(1, 0, 0, 0, 0, 0, 1);

    // Reset window, then ROB of 4 drains in 4 fires.
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("reset_stall", int'(bus.is_any_full), 1);
        chk("reset_rob", int'(bus.rob_free), ROB);
        chk("reset_fire", int'(bus.issue_fire), 0);
      end
      nf += int'(bus.issue_fire);
    end
    chk("rob_fires", nf, 4);
    chk("rob_stall", int'(bus.is_any_full), 1);
    chk("rob_zero", int'(bus.rob_free), 0);
    chk("rs_used", int'(bus.rs_free), RS - 4);

    // Refill ROB, then one extra release overflows.
    @(posedge clk); #1 set(0, 0, 1, 0, 0, 0, 1);
    repeat (5) @(posedge clk);
    #1 set(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("ovf_rob", int'(bus.rob_free), ROB);
    chk("ovf_flag", int'(bus.err_overflow), 1);

    // Three loads, then load + lsb_release in one cycle.
    @(posedge clk); #1 set(1, 1, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 set(1, 1, 0, 0, 1, 0, 1);
    @(negedge clk);
    chk("ls_pre", int'(bus.lsb_free), 3);
    chk("ls_fire", int'(bus.issue_fire), 1);
    @(posedge clk); #1 set(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("ls_net0", int'(bus.lsb_free), 3);
    chk("ls_rob", int'(bus.rob_free), 0);

    // Flush: 2 stalled cycles, counters reloaded, releases dropped.
    @(posedge clk); #1 set(1, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1 set(1, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    chk("hold1_stall", int'(bus.is_any_full), 1);
    chk("hold1_rs", int'(bus.rs_free), RS);
    chk("hold1_lsb", int'(bus.lsb_free), LSB);
    @(negedge clk);
    chk("hold2_stall", int'(bus.is_any_full), 1);
    chk("hold2_rob", int'(bus.rob_free), ROB);
    @(posedge clk); #1 set(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("hold_done", int'(bus.is_any_full), 0);
    chk("hold_rob", int'(bus.rob_free), ROB);

    // rdy low freezes everything.
    @(posedge clk); #1 set(1, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 set(1, 0, i[0], !i[0], i[0], 0, 0);
      @(negedge clk);
      chk("frz_fire", int'(bus.issue_fire), 0);
      chk("frz_rob", int'(bus.rob_free), 2);
      chk("frz_rs", int'(bus.rs_free), RS - 2);
      @(posedge clk);
    end

    // Fill the RS with ROB kept level, then free one slot.
    #1 set(0, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1 set(1, 0, 1, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    nf = 0;
    repeat (16) begin
      @(negedge clk);
      nf += int'(bus.issue_fire);
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    chk("rs_fires", nf, 16);
    chk("rs_zero", int'(bus.rs_free), 0);
    chk("rs_stall", int'(bus.is_any_full), 1);
    @(posedge clk); #1 set(1, 0, 1, 1, 0, 0, 1);
    @(posedge clk); #1 set(1, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    chk("rs_one", int'(bus.rs_free), 1);
    nf = int'(bus.issue_fire);
    repeat (2) begin
      @(negedge clk);
      nf += int'(bus.issue_fire);
    end
    chk("rs_one_fire", nf, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      set($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    set(0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/issue_credit_ctrl.md
# issue_credit_ctrl

Credit-based issue-stall controller between the instruction fetcher / issuer pair and the three back-end structures: reorder buffer, reservation station and load/store buffer. It keeps one free-slot counter per structure, debits it on every instruction accepted for issue and credits it on every slot release. From these counters it drives the single `is_any_full` stall line consumed by the fetcher and issuer. It also sequences the post-reset and post-flush recovery window during which issue is blocked.

## Interface
- `ROB_SIZE`, default 16: reorder-buffer entries.
- `RS_SIZE`, default 16: reservation-station entries.
- `LSB_SIZE`, default 16: load/store-buffer entries.
- `CNT_W`, default 5: counter width; must hold the largest SIZE value (≥ $clog2(max SIZE)+1).
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `rdy  in  1`: global enable; low freezes all state.
- `flush  in  1`: misprediction flush, driven by the ROB reset bus.
- `issue_req  in  1`: fetcher has a decoded instruction ready this cycle.
- `issue_is_ls  in  1`: that instruction is a load or store.
- `rob_release  in  1`: ROB committed one entry.
- `rs_release  in  1`: RS dispatched and freed one entry.
- `lsb_release  in  1`: LSB retired one entry.
- `is_any_full  out  1`: stall; issue is allowed only when low.
- `issue_fire  out  1`: `issue_req & ~is_any_full & rdy`, i.e. the instruction is accepted this cycle.
- `rob_free  out  CNT_W`: ROB free-slot count.
- `rs_free  out  CNT_W`: RS free-slot count.
- `lsb_free  out  CNT_W`: LSB free-slot count.
- `err_overflow  out  1`: sticky; a release arrived while the matching counter was already at SIZE.
- `err_underflow  out  1`: sticky; a debit was attempted at 0. Unreachable in a correct design.

## Operation
- FSM states:
  - INIT: entered on reset. Counters load SIZE; stall forced. Goes to RUN after 1 cycle.
  - RUN: normal operation.
  - HOLD: entered on `flush`. Counters load SIZE; stall forced. Goes to RUN after 2 cycles, which covers the issuer's registered outputs and the ROB reset latency.
- Transitions:
  - `flush` in any state enters HOLD, and HOLD's cycle count restarts.
  - `rst` overrides `flush`.
- Stall rule: in RUN, `is_any_full = (rob_free==0) | (rs_free==0) | (lsb_free==0)`.
  - Any-structure-empty is deliberately conservative: a non-memory instruction also stalls when only the LSB is full.
- Debit on `issue_fire`:
  - `rob_free` decrements.
  - If `issue_is_ls`, `lsb_free` decrements; otherwise `rs_free` decrements.
- Credit: each release input increments its counter by 1.
- Debit and credit on the same counter in the same cycle: net 0, counter unchanged.
- Boundaries:
  - A release at SIZE is ignored and sets `err_overflow`.
  - A debit at 0 is ignored and sets `err_underflow`.
  - Counters never wrap.
- Releases arriving during INIT or HOLD are discarded; the flush has already invalidated those entries.
- `rdy` low:
  - No state change.
  - `issue_fire` is 0.
  - `is_any_full` keeps its value computed from the frozen state.
- Reset values:
  - state INIT
  - all `*_free` = SIZE
  - `is_any_full` = 1
  - `issue_fire` = 0
  - both error flags = 0

## Timing
- `is_any_full` and `issue_fire` are combinational from registered state plus `issue_req` / `rdy`. They are valid in the same cycle.
- Counters update at the clock edge following the fire. A fire that takes the last slot raises `is_any_full` in the next cycle, so back-to-back issue never overcommits.
- A release at edge N makes the slot usable for a fire in cycle N+1.
- Stall duration:
  - After `rst` deasserts: exactly 1 stalled cycle.
  - After a single-cycle `flush`: exactly 2 stalled cycles, with `is_any_full` low again in the 3rd cycle.

## Configuration
- `ISSUE_CREDIT_STATS_EN` defined:
  - Adds 32-bit output counters `stall_cycles`, `stall_rob`, `stall_rs`, `stall_lsb`, cleared on `rst` only.
  - Each increments when `issue_req & is_any_full & rdy` in RUN and its cause holds. Several cause counters may increment in the same cycle.
- Undefined: these ports and registers are absent, and behaviour is otherwise identical.

## Structure
- Shared package:
  - FSM state encoding (INIT/RUN/HOLD).
  - HOLD length constant (2).
  - Default SIZE constants, shared with the ROB/RS/LSB modules.
- One sub-module, `credit_counter`, instantiated three times.
  - Parameterised by SIZE.
  - Inputs: debit, credit, load-full.
  - Outputs: count, zero, overflow/underflow pulses.

## Test plan
- Reset, then `issue_req` held high with no releases, `ROB_SIZE=4`: `issue_fire` high for 4 cycles, then `is_any_full`=1 and `rob_free`=0.
- 16 non-memory issues with `RS_SIZE=16`: `rs_free`=0 and stall asserted. One `rs_release` pulse gives `rs_free`=1 next cycle and exactly one more fire.
- Issue with `issue_is_ls`=1 plus `lsb_release` in the same cycle, starting from `lsb_free`=3: `lsb_free` stays 3 and `rob_free` drops by 1.
- `flush` pulse with all counters partially used: `is_any_full` high for exactly 2 cycles, all counters = SIZE, and a `rob_release` during HOLD is ignored.
- `rob_release` while `rob_free`=SIZE: count unchanged and `err_overflow` latches 1 until `rst`.
- `rdy` low for 3 cycles with `issue_req`=1 and releases toggling: all counters unchanged and `issue_fire`=0.
